// File: rtl/i2c_target_pkg.sv
// rtl/i2c_target_pkg.sv - shared state encoding, bit values and pointer width for the I2C target
package i2c_target_pkg;

    // Pointer / data word width
    localparam int PTR_W = 16;

    // Bus-level value of the acknowledge bit
    localparam logic BIT_ACK  = 1'b0;
    localparam logic BIT_NACK = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_PTR_HI,
        ST_PTR_LO,
        ST_WR_HI,
        ST_WR_LO,
        ST_RD_HI,
        ST_RD_LO,
        ST_WAIT
    } state_e;

endpackage

// File: rtl/i2c_bus_monitor.sv
// rtl/i2c_bus_monitor.sv - SCL/SDA synchronizer, edge detect and START/STOP detect
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   scl_in, sda_in      raw asynchronous bus pins
//   scl_rise, scl_fall  1-clk SCL edge strobes
//   sda_s               synchronized SDA
//   start, stop         1-clk bus condition strobes
module i2c_bus_monitor #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic sda_s,
    output logic start,
    output logic stop
);

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic                   scl_prev_q, scl_prev_d;
    logic                   sda_prev_q, sda_prev_d;
    logic                   scl_s;

    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_in};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
        scl_prev_d = scl_sync_q[SYNC_STAGES-1];
        sda_prev_d = sda_sync_q[SYNC_STAGES-1];
    end

    // Preset high so a reset never looks like a START/STOP on an idle bus
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
        end
    end

    assign scl_s    = scl_sync_q[SYNC_STAGES-1];
    assign sda_s    = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise = scl_s & ~scl_prev_q;
    assign scl_fall = ~scl_s & scl_prev_q;
    // SDA may only change with SCL low, so an SDA edge with SCL high on both samples is a condition
    assign start    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/i2c_target.sv
// rtl/i2c_target.sv - word-addressed I2C target with 16-bit auto-incrementing pointer
//
// Ports:
//   clk, reset    system clock, synchronous active-high reset
//   scl_in/sda_in raw bus pins
//   sda_oe        1 pulls SDA low (open drain)
//   mem_addr      current word pointer; mem_rdata valid 1 clk after it changes
//   mem_wdata/mem_we  write word and 1-clk strobe
//   busy          matched address until STOP
//   stop_pulse    every STOP; nack_pulse  controller NACKed a read byte
module i2c_target
    import i2c_target_pkg::*;
#(
    parameter logic [6:0] DEVICE_ADDR = 7'h33,
    parameter int         SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             scl_in,
    input  logic             sda_in,
    output logic             sda_oe,
    output logic [PTR_W-1:0] mem_addr,
    input  logic [15:0]      mem_rdata,
    output logic [15:0]      mem_wdata,
    output logic             mem_we,
    output logic             busy,
    output logic             stop_pulse,
    output logic             nack_pulse
);

    logic scl_rise, scl_fall, sda_s, start, stop;

    i2c_bus_monitor #(.SYNC_STAGES(SYNC_STAGES)) u_mon (
        .clk      (clk),
        .reset    (reset),
        .scl_in   (scl_in),
        .sda_in   (sda_in),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .sda_s    (sda_s),
        .start    (start),
        .stop     (stop)
    );

    state_e             state_q, state_d;
    logic [3:0]         bit_cnt_q, bit_cnt_d;
    logic               ack_phase_q, ack_phase_d;   // inside the 9th (acknowledge) bit
    logic [7:0]         shift_q, shift_d;
    logic [7:0]         hi_q, hi_d;
    logic [15:0]        tx_word_q, tx_word_d;
    logic               sda_oe_q, sda_oe_d;
    logic               busy_q, busy_d;
    logic [PTR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [15:0]        mem_wdata_q, mem_wdata_d;
    logic               mem_we_q, mem_we_d;
    logic               inc_pending_q, inc_pending_d;
    logic               stop_pulse_q, stop_pulse_d;
    logic               nack_pulse_q, nack_pulse_d;
    logic               rx_state, rd_state;
    logic [7:0]         tx_byte;

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        ack_phase_d   = ack_phase_q;
        shift_d       = shift_q;
        hi_d          = hi_q;
        tx_word_d     = tx_word_q;
        sda_oe_d      = sda_oe_q;
        busy_d        = busy_q;
        // A write bumps the pointer one clk after its strobe
        mem_addr_d    = mem_addr_q + {{(PTR_W-1){1'b0}}, inc_pending_q};
        mem_wdata_d   = mem_wdata_q;
        mem_we_d      = 1'b0;
        inc_pending_d = 1'b0;
        stop_pulse_d  = 1'b0;
        nack_pulse_d  = 1'b0;
        rx_state      = state_q inside {ST_ADDR, ST_PTR_HI, ST_PTR_LO, ST_WR_HI, ST_WR_LO};
        rd_state      = state_q inside {ST_RD_HI, ST_RD_LO};
        tx_byte       = (state_q == ST_RD_HI) ? tx_word_q[15:8] : tx_word_q[7:0];

        if (stop) begin
            state_d      = ST_IDLE;
            bit_cnt_d    = 4'd0;
            ack_phase_d  = 1'b0;
            sda_oe_d     = 1'b0;
            busy_d       = 1'b0;
            stop_pulse_d = 1'b1;
        end else if (start) begin
            state_d     = ST_ADDR;
            bit_cnt_d   = 4'd0;
            ack_phase_d = 1'b0;
            sda_oe_d    = 1'b0;
        end else if (rx_state) begin
            if (scl_rise && !ack_phase_q) begin
                shift_d   = {shift_q[6:0], sda_s};
                bit_cnt_d = bit_cnt_q + 4'd1;
            end else if (scl_fall && !ack_phase_q && bit_cnt_q == 4'd8) begin
                if (state_q == ST_ADDR && shift_q[7:1] != DEVICE_ADDR) begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = 4'd0;
                end else begin
                    ack_phase_d = 1'b1;
                    sda_oe_d    = ~BIT_ACK;
                    if (state_q == ST_ADDR) busy_d = 1'b1;
                end
            end else if (scl_fall && ack_phase_q) begin
                // End of our ACK bit: release, then act on the byte just acknowledged
                ack_phase_d = 1'b0;
                bit_cnt_d   = 4'd0;
                sda_oe_d    = 1'b0;
                case (state_q)
                    ST_ADDR: begin
                        if (shift_q[0]) begin
                            state_d   = ST_RD_HI;
                            tx_word_d = mem_rdata;
                            sda_oe_d  = ~mem_rdata[15];
                        end else begin
                            state_d = ST_PTR_HI;
                        end
                    end
                    ST_PTR_HI: begin
                        hi_d    = shift_q;
                        state_d = ST_PTR_LO;
                    end
                    ST_PTR_LO: begin
                        mem_addr_d = {hi_q, shift_q};
                        state_d    = ST_WR_HI;
                    end
                    ST_WR_HI: begin
                        hi_d    = shift_q;
                        state_d = ST_WR_LO;
                    end
                    default: begin
                        mem_wdata_d   = {hi_q, shift_q};
                        mem_we_d      = 1'b1;
                        inc_pending_d = 1'b1;
                        state_d       = ST_WR_HI;
                    end
                endcase
            end
        end else if (rd_state) begin
            if (scl_rise && !ack_phase_q) begin
                bit_cnt_d = bit_cnt_q + 4'd1;
            end else if (scl_fall && !ack_phase_q) begin
                if (bit_cnt_q == 4'd8) begin
                    sda_oe_d    = 1'b0;
                    ack_phase_d = 1'b1;
                end else begin
                    sda_oe_d = ~tx_byte[3'd7 - bit_cnt_q[2:0]];
                end
            end else if (scl_rise && ack_phase_q) begin
                // Pointer moves at the ACK sample so the next word has settled by the following fall
                if (state_q == ST_RD_LO) mem_addr_d = mem_addr_q + 1'b1;
                if (sda_s == BIT_NACK) begin
                    nack_pulse_d = 1'b1;
                    state_d      = ST_WAIT;
                    ack_phase_d  = 1'b0;
                    bit_cnt_d    = 4'd0;
                end
            end else if (scl_fall && ack_phase_q) begin
                ack_phase_d = 1'b0;
                bit_cnt_d   = 4'd0;
                if (state_q == ST_RD_HI) begin
                    state_d  = ST_RD_LO;
                    sda_oe_d = ~tx_word_q[7];
                end else begin
                    state_d   = ST_RD_HI;
                    tx_word_d = mem_rdata;
                    sda_oe_d  = ~mem_rdata[15];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            bit_cnt_q     <= 4'd0;
            ack_phase_q   <= 1'b0;
            shift_q       <= 8'd0;
            hi_q          <= 8'd0;
            tx_word_q     <= 16'd0;
            sda_oe_q      <= 1'b0;
            busy_q        <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= 16'd0;
            mem_we_q      <= 1'b0;
            inc_pending_q <= 1'b0;
            stop_pulse_q  <= 1'b0;
            nack_pulse_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            ack_phase_q   <= ack_phase_d;
            shift_q       <= shift_d;
            hi_q          <= hi_d;
            tx_word_q     <= tx_word_d;
            sda_oe_q      <= sda_oe_d;
            busy_q        <= busy_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_we_q      <= mem_we_d;
            inc_pending_q <= inc_pending_d;
            stop_pulse_q  <= stop_pulse_d;
            nack_pulse_q  <= nack_pulse_d;
        end
    end

    assign sda_oe     = sda_oe_q;
    assign busy       = busy_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_we     = mem_we_q;
    assign stop_pulse = stop_pulse_q;
    assign nack_pulse = nack_pulse_q;

endmodule

// File: tb/tb_i2c_target.sv
// tb/tb_i2c_target.sv - self-checking bench for i2c_target with bus-level controller and word memory
module tb_i2c_target;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        scl_c = 1'b1;
    logic        sda_c = 1'b1;
    logic        sda_oe;
    logic [15:0] mem_addr;
    logic [15:0] mem_rdata = 16'd0;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic        busy;
    logic        stop_pulse;
    logic        nack_pulse;
    logic        sda_bus;

    assign sda_bus = sda_c & ~sda_oe;

    always #5 clk = ~clk;

    i2c_target dut (
        .clk        (clk),
        .reset      (reset),
        .scl_in     (scl_c),
        .sda_in     (sda_bus),
        .sda_oe     (sda_oe),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .busy       (busy),
        .stop_pulse (stop_pulse),
        .nack_pulse (nack_pulse)
    );

    // External word memory (registered read) with a bench backdoor port
    logic [15:0] mem     [0:65535];
    logic [15:0] ref_mem [0:65535];
    logic        bd_we = 1'b0;
    logic [15:0] bd_addr = 16'd0;
    logic [15:0] bd_data = 16'd0;

    always @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        else if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    // Event log sampled mid-cycle
    logic [15:0] wr_addr_log[$];
    logic [15:0] wr_data_log[$];
    int stop_cnt = 0;
    int nack_cnt = 0;
    int busy_cyc = 0;

    always @(negedge clk) begin
        if (mem_we) begin
            wr_addr_log.push_back(mem_addr);
            wr_data_log.push_back(mem_wdata);
        end
        if (stop_pulse) stop_cnt <= stop_cnt + 1;
        if (nack_pulse) nack_cnt <= nack_cnt + 1;
        if (busy) busy_cyc <= busy_cyc + 1;
    end

    int n_cmp = 0;
    int n_fail = 0;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1);
    end

    task automatic wait_q;
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic backdoor(input logic [15:0] a, input logic [15:0] d);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        @(posedge clk); #1;
        bd_we = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic bus_bit(input logic b, output logic s);
        scl_c = 1'b0; wait_q;
        sda_c = b;    wait_q;
        scl_c = 1'b1; wait_q;
        s = sda_bus;  wait_q;
    endtask

    task automatic start_cond;
        scl_c = 1'b0; wait_q;
        sda_c = 1'b1; wait_q;
        scl_c = 1'b1; wait_q;
        sda_c = 1'b0; wait_q;
    endtask

    task automatic stop_cond;
        scl_c = 1'b0; wait_q;
        sda_c = 1'b0; wait_q;
        scl_c = 1'b1; wait_q;
        sda_c = 1'b1; wait_q; wait_q;
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
        bus_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic read_byte(input logic ack, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, s);
            b[i] = s;
        end
        bus_bit(ack ? 1'b0 : 1'b1, s);
    endtask

    // Byte i of a big-endian word stream starting at word address base
    function automatic logic [7:0] ref_byte(input logic [15:0] base, input int i);
        logic [15:0] a;
        logic [15:0] w;
        a = base + 16'(i / 2);
        w = ref_mem[a];
        return (i % 2 == 0) ? w[15:8] : w[7:0];
    endfunction

    task automatic test_reset;
        reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL rst_sda_oe: got %0b want 0", sda_oe); end
        n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_mem_we: got %0b want 0", mem_we); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %0b want 0", busy); end
        n_cmp++; if (stop_pulse !== 1'b0) begin n_fail++; $display("FAIL rst_stop_pulse: got %0b want 0", stop_pulse); end
        n_cmp++; if (nack_pulse !== 1'b0) begin n_fail++; $display("FAIL rst_nack_pulse: got %0b want 0", nack_pulse); end
        n_cmp++; if (mem_addr !== 16'h0000) begin n_fail++; $display("FAIL rst_mem_addr: got %h want 0000", mem_addr); end
        n_cmp++; if (mem_wdata !== 16'h0000) begin n_fail++; $display("FAIL rst_mem_wdata: got %h want 0000", mem_wdata); end
        #1;
    endtask

    // Pointer write, repeated START, 4-byte read ending in NACK
    task automatic test_write_read;
        logic ack;
        logic [7:0] b;
        logic [7:0] ptr_bytes [2];
        int nb, sb;
        ptr_bytes[0] = 8'h24; ptr_bytes[1] = 8'h00;
        backdoor(16'h2400, 16'hA1B2);
        backdoor(16'h2401, 16'hC3D4);
        nb = nack_cnt; sb = stop_cnt;
        start_cond;
        write_byte(8'h66, ack);
        n_cmp++; if (ack !== 1'b1) begin n_fail++; $display("FAIL wr_rd_addr_ack: got %0b want 1", ack); end
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL wr_rd_busy: got %0b want 1", busy); end
        for (int i = 0; i < 2; i++) begin
            write_byte(ptr_bytes[i], ack);
            n_cmp++; if (ack !== 1'b1) begin n_fail++; $display("FAIL wr_rd_ptr_ack%0d: got %0b want 1", i, ack); end
        end
        start_cond;
        write_byte(8'h67, ack);
        n_cmp++; if (ack !== 1'b1) begin n_fail++; $display("FAIL wr_rd_raddr_ack: got %0b want 1", ack); end
        for (int i = 0; i < 4; i++) begin
            read_byte(i != 3, b);
            n_cmp++; if (b !== ref_byte(16'h2400, i)) begin n_fail++; $display("FAIL wr_rd_byte%0d: got %h want %h", i, b, ref_byte(16'h2400, i)); end
        end
        n_cmp++; if (nack_cnt - nb !== 1) begin n_fail++; $display("FAIL wr_rd_nack_pulses: got %0d want 1", nack_cnt - nb); end
        n_cmp++; if (stop_cnt - sb !== 0) begin n_fail++; $display("FAIL wr_rd_stop_before: got %0d want 0", stop_cnt - sb); end
        n_cmp++; if (mem_addr !== 16'h2402) begin n_fail++; $display("FAIL wr_rd_final_addr: got %h want 2402", mem_addr); end
        stop_cond;
        n_cmp++; if (stop_cnt - sb !== 1) begin n_fail++; $display("FAIL wr_rd_stop_after: got %0d want 1", stop_cnt - sb); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wr_rd_busy_after: got %0b want 0", busy); end
    endtask

    task automatic test_addr_nack;
        logic ack;
        int bc, wc;
        bc = busy_cyc; wc = wr_addr_log.size();
        start_cond;
        write_byte({7'h34, 1'b0}, ack);
        n_cmp++; if (ack !== 1'b0) begin n_fail++; $display("FAIL nack_addr_ack: got %0b want 0", ack); end
        write_byte(8'h00, ack);
        stop_cond;
        n_cmp++; if (busy_cyc - bc !== 0) begin n_fail++; $display("FAIL nack_addr_busy_cycles: got %0d want 0", busy_cyc - bc); end
        n_cmp++; if (wr_addr_log.size() - wc !== 0) begin n_fail++; $display("FAIL nack_addr_writes: got %0d want 0", wr_addr_log.size() - wc); end
    endtask

    // Write a word burst at ptr (optionally plus one trailing odd byte), then STOP
    task automatic do_write(input logic [15:0] ptr, input logic [15:0] words [$], input logic odd, input logic [7:0] odd_b, input string tag);
        logic ack;
        int base;
        base = wr_addr_log.size();
        start_cond;
        write_byte(8'h66, ack);
        n_cmp++; if (ack !== 1'b1) begin n_fail++; $display("FAIL %s_addr_ack: got %0b want 1", tag, ack); end
        write_byte(ptr[15:8], ack);
        write_byte(ptr[7:0], ack);
        for (int i = 0; i < words.size(); i++) begin
            write_byte(words[i][15:8], ack);
            write_byte(words[i][7:0], ack);
            n_cmp++; if (ack !== 1'b1) begin n_fail++; $display("FAIL %s_data_ack%0d: got %0b want 1", tag, i, ack); end
        end
        if (odd) write_byte(odd_b, ack);
        stop_cond;
        n_cmp++; if (wr_addr_log.size() - base !== words.size()) begin n_fail++; $display("FAIL %s_write_count: got %0d want %0d", tag, wr_addr_log.size() - base, words.size()); end
        for (int i = 0; i < words.size() && base + i < wr_addr_log.size(); i++) begin
            logic [15:0] ea;
            ea = ptr + 16'(i);
            n_cmp++; if (wr_addr_log[base + i] !== ea || wr_data_log[base + i] !== words[i]) begin
                n_fail++; $display("FAIL %s_write%0d: got %h=%h want %h=%h", tag, i, wr_addr_log[base + i], wr_data_log[base + i], ea, words[i]);
            end
            ref_mem[ea] = words[i];
        end
    endtask

    // Set pointer, repeated START, read nwords words with final NACK, then STOP
    task automatic do_read(input logic [15:0] ptr, input int nwords, input string tag);
        logic ack;
        logic [7:0] b;
        logic [15:0] ea;
        start_cond;
        write_byte(8'h66, ack);
        write_byte(ptr[15:8], ack);
        write_byte(ptr[7:0], ack);
        start_cond;
        write_byte(8'h67, ack);
        n_cmp++; if (ack !== 1'b1) begin n_fail++; $display("FAIL %s_raddr_ack: got %0b want 1", tag, ack); end
        for (int i = 0; i < 2 * nwords; i++) begin
            read_byte(i != 2 * nwords - 1, b);
            n_cmp++; if (b !== ref_byte(ptr, i)) begin n_fail++; $display("FAIL %s_byte%0d: got %h want %h", tag, i, b, ref_byte(ptr, i)); end
        end
        ea = ptr + 16'(nwords);
        n_cmp++; if (mem_addr !== ea) begin n_fail++; $display("FAIL %s_final_addr: got %h want %h", tag, mem_addr, ea); end
        stop_cond;
    endtask

    task automatic test_write_burst;
        logic [15:0] w[$];
        w = {16'h0123, 16'h4567};
        do_write(16'h8000, w, 1'b1, 8'h89, "burst");
    endtask

    task automatic test_wrap;
        backdoor(16'hFFFF, 16'($urandom));
        backdoor(16'h0000, 16'($urandom));
        do_read(16'hFFFF, 2, "wrap");
    endtask

    task automatic test_back_to_back;
        for (int it = 0; it < 3; it++) begin
            logic [15:0] ptr;
            logic [15:0] w[$];
            int n;
            ptr = 16'($urandom);
            n = $urandom_range(1, 3);
            w = {};
            for (int i = 0; i < n; i++) w.push_back(16'($urandom));
            do_write(ptr, w, 1'b0, 8'h00, "rand_wr");
            do_read(ptr, n, "rand_rd");
        end
    endtask

    task automatic test_reset_mid_read;
        logic ack;
        logic [7:0] b;
        logic [15:0] p;
        int waited;
        p = 16'($urandom_range(1, 65535));
        backdoor(p, 16'($urandom) & 16'h7FFF);
        backdoor(16'h0000, 16'($urandom));
        start_cond;
        write_byte(8'h66, ack);
        write_byte(p[15:8], ack);
        write_byte(p[7:0], ack);
        start_cond;
        write_byte(8'h67, ack);
        scl_c = 1'b0;
        waited = 0;
        while (sda_oe !== 1'b1 && waited < 40) begin
            @(posedge clk); #1;
            waited++;
        end
        n_cmp++; if (sda_oe !== 1'b1) begin n_fail++; $display("FAIL midrd_drive: got %0b want 1 within 40 clk", sda_oe); end
        reset = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL midrd_reset_release: got %0b want 0", sda_oe); end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        n_cmp++; if (mem_addr !== 16'h0000) begin n_fail++; $display("FAIL midrd_reset_addr: got %h want 0000", mem_addr); end
        wait_q;
        start_cond;
        write_byte(8'h67, ack);
        n_cmp++; if (ack !== 1'b1) begin n_fail++; $display("FAIL midrd_post_ack: got %0b want 1", ack); end
        for (int i = 0; i < 2; i++) begin
            read_byte(i == 0, b);
            n_cmp++; if (b !== ref_byte(16'h0000, i)) begin n_fail++; $display("FAIL midrd_post_byte%0d: got %h want %h", i, b, ref_byte(16'h0000, i)); end
        end
        stop_cond;
    endtask

    initial begin
        test_reset;
        test_write_read;
        test_addr_nack;
        test_write_burst;
        test_wrap;
        test_back_to_back;
        test_reset_mid_read;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
